// File: rtl/dpfifo_pkg.sv
// Shared constants and types for the dpram_1024x8 FIFO controller.
package dpfifo_pkg;

  localparam int DPFIFO_ADDR_W = 10;
  localparam int DPFIFO_DATA_W = 8;
  localparam int DPFIFO_DEPTH  = 1 << DPFIFO_ADDR_W;

  // Pointer with one extra wrap bit above the address bits.
  typedef logic [DPFIFO_ADDR_W:0] dpfifo_ptr_t;

endpackage : dpfifo_pkg

// File: rtl/dpfifo_ptr.sv
// FIFO pointer: ADDR_W address bits plus a wrap bit in the MSB.
// Exposes both the registered value and the next-state value so the
// parent can register flags that line up with the pointers.
module dpfifo_ptr #(
  parameter int ADDR_W = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  output logic [ADDR_W:0] o_ptr,
  output logic [ADDR_W:0] o_ptr_nxt
);

  logic [ADDR_W:0] r_ptr;
  logic [ADDR_W:0] w_ptr_nxt;

  // Next pointer; natural overflow of the low bits carries into the wrap bit.
  always_comb begin
    w_ptr_nxt = r_ptr + {{ADDR_W{1'b0}}, i_inc};
  end

  // Pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_ptr     = r_ptr;
  assign o_ptr_nxt = w_ptr_nxt;

endmodule : dpfifo_ptr

// File: rtl/dpram_1024x8_fifo_ctrl.sv
// Single-clock FIFO controller driving one dpram_1024x8 tile.
// Owns the pointers, occupancy count, full/empty flags and the read-data
// valid flag. The memory has a 1-cycle registered read, so pop_data is
// the memory output and is qualified by pop_valid one cycle after a pop.
// Reset asserts asynchronously; its release is expected to be synchronous
// to clk.
// Optional feature macro: DPFIFO_ERR_FLAGS_EN adds err_clr, overflow and
// underflow (sticky error flags for rejected requests).
module dpram_1024x8_fifo_ctrl
  import dpfifo_pkg::*;
#(
  parameter int ADDR_W = DPFIFO_ADDR_W,
  parameter int DATA_W = DPFIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef DPFIFO_ERR_FLAGS_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  logic [ADDR_W:0] w_wr_ptr;
  logic [ADDR_W:0] w_wr_nxt;
  logic [ADDR_W:0] w_rd_ptr;
  logic [ADDR_W:0] w_rd_nxt;
  logic            w_push_acc;
  logic            w_pop_acc;

  logic            r_full;
  logic            r_empty;
  logic [ADDR_W:0] r_count;
  logic            r_pop_valid;

  // Accept terms; held off while reset is asserted so the memory sees no
  // strobes during reset. A push on a full FIFO is dropped even if a pop
  // frees a slot in the same cycle, and a pop never bypasses a push.
  always_comb begin
    w_push_acc = rst_n & push & ~r_full;
    w_pop_acc  = rst_n & pop  & ~r_empty;
  end

  dpfifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_inc     (w_push_acc),
    .o_ptr     (w_wr_ptr),
    .o_ptr_nxt (w_wr_nxt)
  );

  dpfifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_inc     (w_pop_acc),
    .o_ptr     (w_rd_ptr),
    .o_ptr_nxt (w_rd_nxt)
  );

  // Flags and count registered from next-state pointers so they always
  // agree with the pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_count <= '0;
    end else begin
      r_full  <= (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0]) &&
                 (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]);
      r_empty <= (w_wr_nxt == w_rd_nxt);
      r_count <= w_wr_nxt - w_rd_nxt;
    end
  end

  // Read-data valid follows an accepted pop by the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_acc;
    end
  end

`ifdef DPFIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (push & r_full)  | (r_overflow  & ~err_clr);
      r_underflow <= (pop  & r_empty) | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  // Memory port drive; addresses always show the current pointers.
  // Read and write pointers can never address the same word in an
  // accepted cycle, so no collision handling is needed.
  assign mem_waddr   = w_wr_ptr[ADDR_W-1:0];
  assign mem_raddr   = w_rd_ptr[ADDR_W-1:0];
  assign mem_data_in = push_data;
  assign mem_wen     = w_push_acc;
  assign mem_ren     = w_pop_acc;

  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign pop_valid = r_pop_valid;
  assign pop_data  = mem_data_out;

endmodule : dpram_1024x8_fifo_ctrl
